// File: rtl/rx_crc_pkg.sv
// Shared CRC-32 constants, FSM state encoding and the bytewise CRC step for the rx checker.
// The register is MSB-first and not reflected; each byte enters LSB first, as on the wire.
package rx_crc_pkg;

  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT_DEF    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE_DEF = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_next_comb.sv
// Combinational fold of NBYTES bytes into a CRC-32 register; zero latency, no flow control.
// Byte 0 is taken from the MSBs of data.
module crc32_next_comb
  import rx_crc_pkg::*;
#(
  parameter int NBYTES = 8
) (
  input  logic [31:0]         crc_in,
  input  logic [NBYTES*8-1:0] data,
  output logic [31:0]         crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < NBYTES; i++) begin
      c = crc32_byte(c, data[NBYTES*8-1-8*i -: 8]);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_crc_check.sv
// Rx CRC-32 checker: full beats fold in one cycle, a partial last beat drains byte-serially
// with in_ready low; the good/bad pulse lands one cycle after the final fold.
module rx_crc_check
  import rx_crc_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter logic [31:0] CRC_INIT    = CRC_INIT_DEF,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEF,
  parameter int          LEN_W       = 16,
  localparam int         LANES       = DATA_W / 8,
  localparam int         LB_W        = $clog2(LANES) + 1
) (
  input  logic              rxclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LB_W-1:0]   in_last_bytes,
  output logic              crc_ok,
  output logic              crc_err,
  output logic              frame_abort,
  output logic [LEN_W-1:0]  frame_len,
  output logic              busy
);

  localparam logic [LB_W-1:0] LANES_C = LB_W'(LANES);

  state_t            state, state_nxt;
  logic [31:0]       crc_reg, crc_seed, crc_body, crc_tail;
  logic [DATA_W-1:0] tail_sr;
  logic [LB_W-1:0]   tail_cnt;
  logic [LEN_W-1:0]  len_cnt;
  logic              chk_pend, take, full_beat, tail_last;

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input int unsigned b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + (LEN_W + 1)'(b);
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  // Outside a frame only sop beats matter; other accepted beats are silently dropped.
  assign take      = in_valid && in_ready && (in_sop || state == BODY);
  assign full_beat = !in_eop || (in_last_bytes == LANES_C);
  assign tail_last = (tail_cnt <= LB_W'(1));
  assign crc_seed  = in_sop ? CRC_INIT : crc_reg;

  crc32_next_comb #(.NBYTES(LANES)) u_body (
    .crc_in  (crc_seed),
    .data    (in_data),
    .crc_out (crc_body)
  );

  crc32_next_comb #(.NBYTES(1)) u_tail (
    .crc_in  (crc_reg),
    .data    (tail_sr[DATA_W-1 -: 8]),
    .crc_out (crc_tail)
  );

  always_ff @(posedge rxclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, BODY: begin
        if (take) begin
          if (!in_eop)        state_nxt = BODY;
          else if (full_beat) state_nxt = IDLE;
          else                state_nxt = TAIL;
        end
      end
      TAIL:    if (tail_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != TAIL);
    busy     = (state != IDLE);
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      crc_reg     <= CRC_INIT;
      tail_sr     <= '0;
      tail_cnt    <= '0;
      len_cnt     <= '0;
      chk_pend    <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      frame_abort <= 1'b0;
      frame_len   <= '0;
    end else begin
      // Verdict uses the pre-edge register, so a new sop on this edge cannot disturb it.
      crc_ok      <= chk_pend && (crc_reg == CRC_RESIDUE);
      crc_err     <= chk_pend && (crc_reg != CRC_RESIDUE);
      if (chk_pend) frame_len <= len_cnt;
      chk_pend    <= 1'b0;
      frame_abort <= 1'b0;
      if (take) begin
        frame_abort <= in_sop && (state == BODY);
        if (full_beat) begin
          crc_reg  <= crc_body;
          len_cnt  <= in_sop ? sat_add('0, LANES) : sat_add(len_cnt, LANES);
          chk_pend <= in_eop;
        end else begin
          crc_reg  <= crc_seed;
          len_cnt  <= in_sop ? '0 : len_cnt;
          tail_sr  <= in_data;
          tail_cnt <= in_last_bytes;
        end
      end else if (state == TAIL) begin
        crc_reg  <= crc_tail;
        tail_sr  <= tail_sr << 8;
        tail_cnt <= tail_cnt - LB_W'(1);
        len_cnt  <= sat_add(len_cnt, 1);
        chk_pend <= tail_last;
      end
    end
  end

endmodule

// File: tb/tb_rx_crc_check.sv
// Directed bench for rx_crc_check: a 64-bit and a 32-bit instance share clock and reset.
// FCS values come from a reflected (LSB-first) CRC-32 model, independent of the DUT form.
module tb_rx_crc_check;

  logic rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  logic        reset;
  logic        v64, r64, sop64, eop64, ok64, er64, ab64, busy64;
  logic [63:0] d64;
  logic [3:0]  lb64;
  logic [15:0] len64;
  logic        v32, r32, sop32, eop32, ok32, er32, ab32, busy32;
  logic [31:0] d32;
  logic [2:0]  lb32;
  logic [15:0] len32;

  rx_crc_check #(.DATA_W(64)) u64 (
    .rxclk(rxclk), .reset(reset), .in_valid(v64), .in_ready(r64), .in_sop(sop64),
    .in_eop(eop64), .in_data(d64), .in_last_bytes(lb64), .crc_ok(ok64), .crc_err(er64),
    .frame_abort(ab64), .frame_len(len64), .busy(busy64)
  );

  rx_crc_check #(.DATA_W(32)) u32 (
    .rxclk(rxclk), .reset(reset), .in_valid(v32), .in_ready(r32), .in_sop(sop32),
    .in_eop(eop32), .in_data(d32), .in_last_bytes(lb32), .crc_ok(ok32), .crc_err(er32),
    .frame_abort(ab32), .frame_len(len32), .busy(busy32)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int eop_cyc = 0;

  always @(posedge rxclk) cyc <= cyc + 1;

  int          n_ok64 = 0, n_err64 = 0, n_ab64 = 0, ok64_at = 0, err64_at = 0, low64 = 0;
  int          n_ok32 = 0, n_err32 = 0, n_ab32 = 0;
  logic [15:0] len64_pulse = '0;
  logic [15:0] len32_log [0:3];

  always @(negedge rxclk) begin
    if (ok64) begin n_ok64++; ok64_at = cyc; len64_pulse = len64; end
    if (er64) begin n_err64++; err64_at = cyc; len64_pulse = len64; end
    if (ab64) n_ab64++;
    if (r64 === 1'b0) low64++;
    if (ok32) begin
      if (n_ok32 < 4) len32_log[n_ok32] = len32;
      n_ok32++;
    end
    if (er32) n_err32++;
    if (ab32) n_ab32++;
  end

  logic [7:0] frm [0:127];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Payload of n-4 bytes followed by the Ethernet FCS, low byte first.
  task automatic build(input int n, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      frm[i] = 8'((i * 13 + seed) & 255);
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm[n-4] = c[7:0];
    frm[n-3] = c[15:8];
    frm[n-2] = c[23:16];
    frm[n-1] = c[31:24];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  task automatic beat(input bit w32, input bit sop, input bit eop, input logic [63:0] d, input int lb);
    bit rdy;
    int guard;
    if (w32) begin v32 = 1'b1; sop32 = sop; eop32 = eop; d32 = d[31:0]; lb32 = 3'(lb); end
    else     begin v64 = 1'b1; sop64 = sop; eop64 = eop; d64 = d;       lb64 = 4'(lb); end
    guard = 0;
    do begin
      @(negedge rxclk);
      rdy = w32 ? r32 : r64;
      @(posedge rxclk);
      guard++;
    end while (!rdy && guard < 64);
    #1;
    chk("beat_accepted", 32'(rdy), 32'd1);
    eop_cyc = cyc;
    v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
    v64 = 1'b0; sop64 = 1'b0; eop64 = 1'b0;
  endtask

  task automatic send(input bit w32, input int n, input int max_beats, input bit gap);
    int          lanes, nb;
    logic [63:0] d;
    bit          eop;
    lanes = w32 ? 4 : 8;
    nb = 0;
    for (int b = 0; b < n && nb < max_beats; b += lanes) begin
      d = '0;
      for (int k = 0; k < lanes; k++) d = {d[55:0], (b + k < n) ? frm[b+k] : 8'hEE};
      eop = (b + lanes >= n);
      beat(w32, b == 0, eop, d, eop ? n - b : lanes);
      nb++;
      if (gap) idle(1);
    end
  endtask

  int b_ok, b_err, b_ab, b_low, e;

  task automatic snap();
    b_ok = n_ok64; b_err = n_err64; b_ab = n_ab64; b_low = low64;
  endtask

  initial begin
    reset = 1'b1;
    v64 = 0; sop64 = 0; eop64 = 0; d64 = '0; lb64 = '0;
    v32 = 0; sop32 = 0; eop32 = 0; d32 = '0; lb32 = '0;
    repeat (3) @(posedge rxclk);
    @(negedge rxclk);
    chk("rst_in_ready", 32'(r64), 32'd1);
    chk("rst_crc_ok", 32'(ok64), 32'd0);
    chk("rst_crc_err", 32'(er64), 32'd0);
    chk("rst_abort", 32'(ab64), 32'd0);
    chk("rst_frame_len", 32'(len64), 32'd0);
    chk("rst_busy", 32'(busy64), 32'd0);
    @(posedge rxclk); #1;
    reset = 1'b0;
    idle(2);

    // Good 64-byte frame, eight full beats.
    snap(); build(64, 1); send(0, 64, 99, 0); e = eop_cyc; idle(6);
    chk("good64_ok_count", 32'(n_ok64 - b_ok), 32'd1);
    chk("good64_err_count", 32'(n_err64 - b_err), 32'd0);
    chk("good64_ok_cycle", 32'(ok64_at), 32'(e + 1));
    chk("good64_len", 32'(len64_pulse), 32'd64);

    // Same frame with payload byte 10 bit 0 flipped.
    snap(); build(64, 1); frm[10] = frm[10] ^ 8'h01; send(0, 64, 99, 0); e = eop_cyc; idle(6);
    chk("bad64_err_count", 32'(n_err64 - b_err), 32'd1);
    chk("bad64_ok_count", 32'(n_ok64 - b_ok), 32'd0);
    chk("bad64_err_cycle", 32'(err64_at), 32'(e + 1));
    chk("bad64_len", 32'(len64_pulse), 32'd64);

    // 67-byte frame: three-byte tail.
    snap(); build(67, 7); send(0, 67, 99, 0); e = eop_cyc; idle(8);
    chk("tail67_ok_count", 32'(n_ok64 - b_ok), 32'd1);
    chk("tail67_ready_low", 32'(low64 - b_low), 32'd3);
    chk("tail67_ok_cycle", 32'(ok64_at), 32'(e + 4));
    chk("tail67_len", 32'(len64_pulse), 32'd67);

    // Four beats of a frame, then a fresh sop carrying a complete good frame.
    snap(); build(64, 40); send(0, 64, 4, 0);
    build(64, 90); send(0, 64, 99, 0); idle(6);
    chk("abort_pulses", 32'(n_ab64 - b_ab), 32'd1);
    chk("abort_ok_count", 32'(n_ok64 - b_ok), 32'd1);
    chk("abort_err_count", 32'(n_err64 - b_err), 32'd0);
    chk("abort_len", 32'(len64_pulse), 32'd64);

    // Reset while draining a five-byte tail.
    snap(); build(61, 22); send(0, 61, 99, 0);
    @(posedge rxclk); #1;
    reset = 1'b1;
    @(posedge rxclk); #1;
    reset = 1'b0;
    @(negedge rxclk);
    chk("rst_tail_in_ready", 32'(r64), 32'd1);
    chk("rst_tail_busy", 32'(busy64), 32'd0);
    idle(8);
    chk("rst_tail_no_ok", 32'(n_ok64 - b_ok), 32'd0);
    chk("rst_tail_no_err", 32'(n_err64 - b_err), 32'd0);
    build(64, 5); send(0, 64, 99, 0); idle(6);
    chk("after_rst_ok", 32'(n_ok64 - b_ok), 32'd1);

    // 32-bit instance: back-to-back 64- and 65-byte frames at half rate.
    build(64, 3); send(1, 64, 99, 1);
    build(65, 77); send(1, 65, 99, 1); idle(10);
    chk("w32_ok_count", 32'(n_ok32), 32'd2);
    chk("w32_err_count", 32'(n_err32), 32'd0);
    chk("w32_abort_count", 32'(n_ab32), 32'd0);
    chk("w32_len_first", 32'(len32_log[0]), 32'd64);
    chk("w32_len_second", 32'(len32_log[1]), 32'd65);
    chk("w32_busy_end", 32'(busy32), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
